// File: rtl/ks_sum_pipe_if.sv
// ============================================================================
// Module : ks_sum_pipe_if
// Brief  : Operand/result stream bundle for the pipelined Kogge-Stone adder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ks_sum_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic [1:0]       OP;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C;
    logic             OVF;

    modport master (
        output in_valid, A, B, CIN, OP, out_ready,
        input  in_ready, out_valid, S, C, OVF
    );

    modport slave (
        input  in_valid, A, B, CIN, OP, out_ready,
        output in_ready, out_valid, S, C, OVF
    );
endinterface

`default_nettype wire

// File: rtl/ks_sum_pipe.sv
// ============================================================================
// Module : ks_sum_pipe
// Brief  : Pipelined Kogge-Stone adder (ADD / INC / SUB) with a valid/ready
//          stream interface; every prefix level is registered.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ks_sum_pipe #(
    parameter int WIDTH = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    ks_sum_pipe_if.slave  bus
);

    localparam int LEVELS = $clog2(WIDTH);

    localparam logic [1:0] c_OP_INC = 2'b01;
    localparam logic [1:0] c_OP_SUB = 2'b10;

    logic                           w_stall;
    logic [WIDTH-1:0]               w_b_eff;
    logic                           w_cin_eff;
    logic [WIDTH-1:0]               w_p0;

    // Index 0 of the next-state arrays is the input stage; index k is the
    // output of prefix level k. The last level's group-propagate is never
    // consumed, so P is only kept up to level LEVELS-1.
    logic [LEVELS:0][WIDTH-1:0]     w_g_nxt;
    logic [LEVELS-1:0][WIDTH-1:0]   w_p_nxt;

    logic [LEVELS:0]                r_valid;
    logic [LEVELS:0][WIDTH-1:0]     r_g;
    logic [LEVELS-1:0][WIDTH-1:0]   r_p;
    logic [LEVELS:0][WIDTH-1:0]     r_po;
    logic [LEVELS:0]                r_cin;

    // The whole pipe advances or holds as one unit, so ready only depends
    // on the last stage and the consumer.
    assign w_stall      = r_valid[LEVELS] & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    assign w_b_eff   = (bus.OP == c_OP_SUB) ? ~bus.B : bus.B;
    assign w_cin_eff = (bus.OP == c_OP_INC || bus.OP == c_OP_SUB) ? 1'b1 : bus.CIN;
    assign w_p0      = bus.A ^ w_b_eff;

    // Carry-in enters as a generate at position -1, folded into bit 0.
    assign w_g_nxt[0] = (bus.A & w_b_eff) | {{(WIDTH-1){1'b0}}, w_p0[0] & w_cin_eff};
    assign w_p_nxt[0] = w_p0;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int DIST = 1 << (k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= DIST) begin : g_merge
                assign w_g_nxt[k][i] = r_g[k-1][i] | (r_p[k-1][i] & r_g[k-1][i-DIST]);
                if (k < LEVELS) begin : g_prop
                    assign w_p_nxt[k][i] = r_p[k-1][i] & r_p[k-1][i-DIST];
                end
            end else begin : g_pass
                assign w_g_nxt[k][i] = r_g[k-1][i];
                if (k < LEVELS) begin : g_prop
                    assign w_p_nxt[k][i] = r_p[k-1][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_g     <= '0;
            r_p     <= '0;
            r_po    <= '0;
            r_cin   <= '0;
        end else if (!w_stall) begin
            r_valid <= {r_valid[LEVELS-1:0], bus.in_valid};
            r_po    <= {r_po[LEVELS-1:0], w_p0};
            r_cin   <= {r_cin[LEVELS-1:0], w_cin_eff};
            for (int k = 0; k <= LEVELS; k++) begin
                r_g[k] <= w_g_nxt[k];
            end
            for (int k = 0; k < LEVELS; k++) begin
                r_p[k] <= w_p_nxt[k];
            end
        end
    end

    // After the last level r_g[i] is the carry out of bit i.
    assign bus.out_valid = r_valid[LEVELS];
    assign bus.S         = r_po[LEVELS] ^ {r_g[LEVELS][WIDTH-2:0], r_cin[LEVELS]};
    assign bus.C         = r_g[LEVELS][WIDTH-1];
    assign bus.OVF       = r_g[LEVELS][WIDTH-1] ^ r_g[LEVELS][WIDTH-2];

endmodule

`default_nettype wire

// File: tb/tb_ks_sum_pipe.sv
// ============================================================================
// Module : tb_ks_sum_pipe
// Brief  : Self-checking bench for ks_sum_pipe at WIDTH 4, 16, 13 and 32.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ks_sum_pipe;

    localparam int NI = 4;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        ovf;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [NI-1:0]   iv;
    logic [NI-1:0]   cin_d;
    logic [NI-1:0]   ordy;
    logic [NI-1:0]   ir;
    logic [NI-1:0]   ov;
    logic [NI-1:0]   c_m;
    logic [NI-1:0]   ovf_m;
    logic [63:0]     a_d   [NI];
    logic [63:0]     b_d   [NI];
    logic [1:0]      op_d  [NI];
    logic [63:0]     s_m   [NI];

    int   total;
    int   bad;
    exp_t expq [NI][$];

    function automatic int wof(input int i);
        case (i)
            0:       return 4;
            1:       return 16;
            2:       return 13;
            default: return 32;
        endcase
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 4 : (gi == 1) ? 16 : (gi == 2) ? 13 : 32;
        ks_sum_pipe_if #(.WIDTH(W)) u_if ();
        assign u_if.in_valid  = iv[gi];
        assign u_if.A         = a_d[gi][W-1:0];
        assign u_if.B         = b_d[gi][W-1:0];
        assign u_if.CIN       = cin_d[gi];
        assign u_if.OP        = op_d[gi];
        assign u_if.out_ready = ordy[gi];
        assign ir[gi]         = u_if.in_ready;
        assign ov[gi]         = u_if.out_valid;
        assign s_m[gi]        = 64'(u_if.S);
        assign c_m[gi]        = u_if.C;
        assign ovf_m[gi]      = u_if.OVF;
        ks_sum_pipe #(.WIDTH(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic [1:0] op);
        logic [63:0] m, aa, be, full;
        logic        ce;
        exp_t        e;
        m     = (64'd1 << w) - 64'd1;
        aa    = a & m;
        be    = ((op == 2'b10) ? ~b : b) & m;
        ce    = (op == 2'b01 || op == 2'b10) ? 1'b1 : cin;
        full  = aa + be + {63'd0, ce};
        e.s   = full & m;
        e.c   = full[w];
        e.ovf = (aa[w-1] == be[w-1]) && (e.s[w-1] != aa[w-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) expq[i].delete();
        end else begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("in_ready rule u%0d", i), 64'(ir[i]), 64'(!(ov[i] && !ordy[i])));
                if (ov[i]) begin
                    if (expq[i].size() == 0) begin
                        chk($sformatf("unexpected out_valid u%0d", i), 64'(ov[i]), 64'd0);
                    end else begin
                        e = expq[i][0];
                        chk($sformatf("model S u%0d", i), s_m[i], e.s);
                        chk($sformatf("model C u%0d", i), 64'(c_m[i]), 64'(e.c));
                        chk($sformatf("model OVF u%0d", i), 64'(ovf_m[i]), 64'(e.ovf));
                        if (ordy[i]) void'(expq[i].pop_front());
                    end
                end
                if (iv[i] && ir[i]) begin
                    expq[i].push_back(model(wof(i), a_d[i], b_d[i], cin_d[i], op_d[i]));
                    chk($sformatf("occupancy u%0d", i),
                        64'(expq[i].size() > ($clog2(wof(i)) + 1)), 64'd0);
                end
            end
        end
    end

    task automatic idle(input int n);
        iv   = '0;
        ordy = '1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stream4();
        logic [3:0] va [5] = '{4'h1, 4'hF, 4'h6, 4'hA, 4'hC};
        logic [3:0] vb [5] = '{4'h2, 4'h1, 4'h6, 4'hB, 4'hC};
        logic [3:0] es [5] = '{4'h3, 4'h0, 4'hC, 4'h5, 4'h8};
        logic [4:0] ec     = 5'b11010;
        logic [4:0] eo     = 5'b01100;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 5) begin
                iv[0]   = 1'b1;
                a_d[0]  = 64'(va[cyc]);
                b_d[0]  = 64'(vb[cyc]);
                cin_d[0] = 1'b0;
                op_d[0] = 2'b00;
            end else begin
                iv[0] = 1'b0;
            end
            @(posedge clk);
            #1;
            chk($sformatf("stream out_valid cyc%0d", cyc), 64'(ov[0]), 64'(cyc >= 2 && cyc <= 6));
            if (cyc >= 2 && cyc <= 6) begin
                chk($sformatf("stream S #%0d", cyc - 2), s_m[0], 64'(es[cyc-2]));
                chk($sformatf("stream C #%0d", cyc - 2), 64'(c_m[0]), 64'(ec[cyc-2]));
                chk($sformatf("stream OVF #%0d", cyc - 2), 64'(ovf_m[0]), 64'(eo[cyc-2]));
            end
        end
    endtask

    task automatic single_op(input int i, input logic [63:0] a, input logic [63:0] b,
                             input logic cin, input logic [1:0] op, input logic [63:0] es,
                             input logic ec, input logic eo, input int lat, input string nm);
        int n;
        iv[i]    = 1'b1;
        a_d[i]   = a;
        b_d[i]   = b;
        cin_d[i] = cin;
        op_d[i]  = op;
        ordy[i]  = 1'b1;
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        n = 1;
        while (!ov[i] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " S"}, s_m[i], es);
        chk({nm, " C"}, 64'(c_m[i]), 64'(ec));
        chk({nm, " OVF"}, 64'(ovf_m[i]), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic backpressure();
        int          idx = 0, outs = 0, stalled = 0, gaps = 0, phase = 0;
        logic        acc;
        logic [63:0] held = '0;
        ordy[1] = 1'b1;
        for (int cyc = 0; cyc < 60 && (idx < 8 || outs < 8); cyc++) begin
            if (idx < 8) begin
                iv[1]    = 1'b1;
                a_d[1]   = 64'h1000 + 64'(idx) * 64'h111;
                b_d[1]   = 64'(idx * 3 + 1);
                cin_d[1] = 1'b0;
                op_d[1]  = 2'b00;
            end else begin
                iv[1] = 1'b0;
            end
            #1;
            acc = iv[1] && ir[1];
            if (ov[1] && ordy[1]) outs++;
            else if (phase == 2 && outs < 8) gaps++;
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (phase == 0 && ov[1]) begin
                phase   = 1;
                ordy[1] = 1'b0;
                held    = s_m[1];
            end else if (phase == 1) begin
                chk("bp in_ready while full", 64'(ir[1]), 64'd0);
                chk("bp out_valid held", 64'(ov[1]), 64'd1);
                chk("bp S steady", s_m[1], held);
                stalled++;
                if (stalled == 6) begin
                    chk("bp occupancy at release", 64'(idx), 64'd5);
                    phase   = 2;
                    ordy[1] = 1'b1;
                end
            end
        end
        chk("bp accepted", 64'(idx), 64'd8);
        chk("bp delivered", 64'(outs), 64'd8);
        chk("bp bubbles after release", 64'(gaps), 64'd0);
        iv[1] = 1'b0;
    endtask

    task automatic reset_mid_flight();
        iv[0]    = 1'b1;
        ordy[0]  = 1'b1;
        cin_d[0] = 1'b0;
        op_d[0]  = 2'b00;
        for (int k = 0; k < 3; k++) begin
            a_d[0] = 64'(k + 1);
            b_d[0] = 64'(k + 4);
            @(posedge clk);
            #1;
        end
        iv[0] = 1'b0;
        chk("pre-reset out_valid", 64'(ov[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(ov[0]), 64'd0);
        chk("async reset S", s_m[0], 64'd0);
        chk("async reset C", 64'(c_m[0]), 64'd0);
        chk("async reset OVF", 64'(ovf_m[0]), 64'd0);
        chk("async reset in_ready", 64'(ir[0]), 64'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("no stale result %0d", k), 64'(ov[0]), 64'd0);
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(7))
            0:       return '1;
            1:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic sweep(input int ncyc);
        logic [NI-1:0] acc = '0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                if (!iv[i] || acc[i]) begin
                    iv[i]    = ($urandom_range(3) != 0);
                    a_d[i]   = pick();
                    b_d[i]   = pick();
                    cin_d[i] = 1'($urandom_range(1));
                    op_d[i]  = 2'($urandom_range(3));
                end
                ordy[i] = ($urandom_range(3) != 0);
            end
            #1;
            for (int i = 0; i < NI; i++) acc[i] = iv[i] && ir[i];
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '1;
        cin_d = '0;
        for (int i = 0; i < NI; i++) begin
            a_d[i]  = '0;
            b_d[i]  = '0;
            op_d[i] = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset out_valid u%0d", i), 64'(ov[i]), 64'd0);
            chk($sformatf("reset in_ready u%0d", i), 64'(ir[i]), 64'd1);
            chk($sformatf("reset S u%0d", i), s_m[i], 64'd0);
            chk($sformatf("reset C u%0d", i), 64'(c_m[i]), 64'd0);
            chk($sformatf("reset OVF u%0d", i), 64'(ovf_m[i]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        stream4();
        idle(2);
        single_op(0, 64'hF, 64'h0, 1'b0, 2'b01, 64'h0, 1'b1, 1'b0, 3, "W4 INC F+0");
        single_op(0, 64'h3, 64'h5, 1'b0, 2'b10, 64'hE, 1'b0, 1'b0, 3, "W4 SUB 3-5");
        single_op(0, 64'h5, 64'h3, 1'b1, 2'b10, 64'h2, 1'b1, 1'b0, 3, "W4 SUB 5-3");
        single_op(0, 64'h7, 64'h8, 1'b1, 2'b11, 64'h0, 1'b1, 1'b0, 3, "W4 OP11 7+8+1");
        single_op(1, 64'hFFFF, 64'h0, 1'b1, 2'b00, 64'h0, 1'b1, 1'b0, 5, "W16 FFFF+0+1");
        single_op(1, 64'h7FFF, 64'h1, 1'b0, 2'b00, 64'h8000, 1'b0, 1'b1, 5, "W16 7FFF+1");
        idle(2);
        backpressure();
        idle(3);
        reset_mid_flight();
        sweep(400);
        idle(12);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("drained u%0d", i), 64'(expq[i].size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
